// File: rtl/regfile_branch_unit.sv
// Register file with $30/$16/$24 taps, branch resolver and next-PC adder.
// Single-cycle datapath slice; reads and branch outputs are combinational.
module regfile_branch_unit #(
    parameter int DATA_WIDTH       = 32,
    parameter int DATA_ADDR_WIDTH  = 13,
    parameter int INSTR_ADDR_WIDTH = 13
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [4:0]                  reg1,
    input  logic [4:0]                  reg2,
    input  logic [4:0]                  reg_escrita,
    input  logic                        reg_write,
    input  logic [DATA_WIDTH-1:0]       escreve_dado,
    input  logic                        clear_offset_base,
    output logic [DATA_WIDTH-1:0]       dado1,
    output logic [DATA_WIDTH-1:0]       dado2,
    output logic [DATA_WIDTH-1:0]       fp,
    output logic [DATA_WIDTH-1:0]       s0,
    output logic [DATA_WIDTH-1:0]       offset_base,
    input  logic                        beq,
    input  logic                        bne,
    input  logic                        zero,
    output logic                        control_branch,
    input  logic [DATA_WIDTH-1:0]       imediato,
    input  logic [INSTR_ADDR_WIDTH-1:0] pc_atual,
    output logic [INSTR_ADDR_WIDTH-1:0] novo_endereco
);

    localparam logic [4:0] FP_IDX = 5'd30;
    localparam logic [4:0] S0_IDX = 5'd16;
    localparam logic [4:0] OB_IDX = 5'd24;

    logic [DATA_WIDTH-1:0] regs_q [32];
    logic [DATA_WIDTH-1:0] regs_d [32];

    // Data-memory width is only carried through for the top level.
    logic [DATA_ADDR_WIDTH-1:0] unused_daddr;
    logic                       unused_imm;
    assign unused_daddr = '0;
    assign unused_imm   = ^imediato[DATA_WIDTH-1:INSTR_ADDR_WIDTH];

    // Clear of $24 is applied last so it wins over a same-cycle write.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (reg_escrita != 5'd0)) begin
            regs_d[reg_escrita] = escreve_dado;
        end
        if (clear_offset_base) begin
            regs_d[OB_IDX] = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign dado1       = (reg1 == 5'd0) ? '0 : regs_q[reg1];
    assign dado2       = (reg2 == 5'd0) ? '0 : regs_q[reg2];
    assign fp          = regs_q[FP_IDX];
    assign s0          = regs_q[S0_IDX];
    assign offset_base = regs_q[OB_IDX];

    assign control_branch = (beq & zero) | (bne & ~zero);

    logic [INSTR_ADDR_WIDTH-1:0] pc_seq;
    logic [INSTR_ADDR_WIDTH-1:0] pc_off;

    assign pc_seq        = pc_atual + INSTR_ADDR_WIDTH'(1);
    assign pc_off        = control_branch ? imediato[INSTR_ADDR_WIDTH-1:0] : '0;
    assign novo_endereco = pc_seq + pc_off;

endmodule

// File: tb/tb_regfile_branch_unit.sv
// Bench for regfile_branch_unit: directed steps then random traffic
// compared against an array-based model of the register file.
module tb_regfile_branch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  reg1, reg2, reg_escrita;
    logic        reg_write;
    logic [31:0] escreve_dado;
    logic        clear_offset_base;
    logic [31:0] dado1, dado2, fp, s0, offset_base;
    logic        beq, bne, zero;
    logic        control_branch;
    logic [31:0] imediato;
    logic [12:0] pc_atual;
    logic [12:0] novo_endereco;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    regfile_branch_unit #(
        .DATA_WIDTH(32),
        .DATA_ADDR_WIDTH(13),
        .INSTR_ADDR_WIDTH(13)
    ) dut (
        .clock(clock),
        .reset(reset),
        .reg1(reg1),
        .reg2(reg2),
        .reg_escrita(reg_escrita),
        .reg_write(reg_write),
        .escreve_dado(escreve_dado),
        .clear_offset_base(clear_offset_base),
        .dado1(dado1),
        .dado2(dado2),
        .fp(fp),
        .s0(s0),
        .offset_base(offset_base),
        .beq(beq),
        .bne(bne),
        .zero(zero),
        .control_branch(control_branch),
        .imediato(imediato),
        .pc_atual(pc_atual),
        .novo_endereco(novo_endereco)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    function automatic logic mtaken(input logic b, input logic n,
                                    input logic z);
        logic taken;
        unique case ({b, n})
            2'b00:   taken = 1'b0;
            2'b10:   taken = z;
            2'b01:   taken = !z;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

    function automatic logic [12:0] mnext(input int pc, input int imm,
                                          input logic taken);
        int t;
        t = pc + 1 + (taken ? (imm % 8192) : 0);
        return 13'(t % 8192);
    endfunction

    // Clock edge with model update; inputs are released 1 unit after.
    task automatic edge_update();
        @(posedge clock);
        if (!reset) begin
            if (reg_write && reg_escrita != 5'd0)
                model[reg_escrita] = escreve_dado;
            if (clear_offset_base)
                model[24] = 32'd0;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic clr);
        reg_write = 1'b1;
        reg_escrita = a;
        escreve_dado = d;
        clear_offset_base = clr;
        edge_update();
        reg_write = 1'b0;
        clear_offset_base = 1'b0;
    endtask

    task automatic chk_all(input string tag);
        logic tk;
        tk = mtaken(beq, bne, zero);
        chk({tag, ".dado1"}, dado1, mread(reg1));
        chk({tag, ".dado2"}, dado2, mread(reg2));
        chk({tag, ".fp"}, fp, model[30]);
        chk({tag, ".s0"}, s0, model[16]);
        chk({tag, ".ob"}, offset_base, model[24]);
        chk({tag, ".br"}, {31'd0, control_branch}, {31'd0, tk});
        chk({tag, ".npc"}, {19'd0, novo_endereco},
            {19'd0, mnext(int'(pc_atual), int'(imediato[30:0]), tk)});
    endtask

    task automatic branch_case(input logic b, input logic n, input logic z,
                               input logic exp);
        beq = b;
        bne = n;
        zero = z;
        #1;
        chk($sformatf("br_%0b%0b%0b", b, n, z),
            {31'd0, control_branch}, {31'd0, exp});
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b1;
        reg1 = 5'd5;
        reg2 = 5'd30;
        reg_escrita = 5'd0;
        reg_write = 1'b0;
        escreve_dado = 32'd0;
        clear_offset_base = 1'b0;
        beq = 1'b0;
        bne = 1'b0;
        zero = 1'b0;
        imediato = 32'd0;
        pc_atual = 13'd0;
        #12;
        chk("rst_dado1", dado1, 32'd0);
        chk("rst_fp", fp, 32'd0);
        chk("rst_ob", offset_base, 32'd0);
        reset = 1'b0;
        #1;

        wr(5'd5, 32'h1234, 1'b0);
        chk("w5_pre_rst", dado1, 32'h1234);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        chk("async_rst", dado1, 32'd0);
        wr(5'd5, 32'h5555, 1'b0);
        chk("wr_in_rst", dado1, 32'd0);
        #2;
        reset = 1'b0;
        #1;

        reg2 = 5'd5;
        wr(5'd5, 32'hDEADBEEF, 1'b0);
        chk("w5_dado1", dado1, 32'hDEADBEEF);
        chk("w5_dado2", dado2, 32'hDEADBEEF);
        reg1 = 5'd0;
        wr(5'd0, 32'hFFFF, 1'b0);
        chk("w0_discard", dado1, 32'd0);

        wr(5'd7, 32'h11, 1'b0);
        reg1 = 5'd7;
        reg_write = 1'b1;
        reg_escrita = 5'd7;
        escreve_dado = 32'hA5;
        #1;
        chk("nobypass_pre", dado1, 32'h11);
        edge_update();
        reg_write = 1'b0;
        chk("nobypass_post", dado1, 32'hA5);

        wr(5'd30, 32'h100, 1'b0);
        wr(5'd16, 32'h22, 1'b0);
        wr(5'd24, 32'h40, 1'b0);
        chk("tap_fp", fp, 32'h100);
        chk("tap_s0", s0, 32'h22);
        chk("tap_ob", offset_base, 32'h40);
        wr(5'd24, 32'h77, 1'b1);
        chk("clr_prio", offset_base, 32'd0);
        wr(5'd9, 32'h99, 1'b1);
        reg1 = 5'd9;
        #1;
        chk("clr_other_wr", dado1, 32'h99);

        branch_case(1'b1, 1'b0, 1'b1, 1'b1);
        branch_case(1'b1, 1'b0, 1'b0, 1'b0);
        branch_case(1'b0, 1'b1, 1'b0, 1'b1);
        branch_case(1'b0, 1'b1, 1'b1, 1'b0);
        branch_case(1'b0, 1'b0, 1'b0, 1'b0);
        branch_case(1'b0, 1'b0, 1'b1, 1'b0);
        branch_case(1'b1, 1'b1, 1'b0, 1'b1);
        branch_case(1'b1, 1'b1, 1'b1, 1'b1);

        pc_atual = 13'd10;
        imediato = 32'd5;
        beq = 1'b1;
        bne = 1'b0;
        zero = 1'b1;
        #1;
        chk("tgt_taken", {19'd0, novo_endereco}, 32'd16);
        zero = 1'b0;
        #1;
        chk("tgt_not", {19'd0, novo_endereco}, 32'd11);
        pc_atual = 13'd8191;
        #1;
        chk("wrap_seq", {19'd0, novo_endereco}, 32'd0);
        pc_atual = 13'd8190;
        imediato = 32'h3;
        zero = 1'b1;
        #1;
        chk("wrap_br", {19'd0, novo_endereco}, 32'd2);
        pc_atual = 13'd0;
        imediato = 32'h2005;
        #1;
        chk("imm_hi_ignored", {19'd0, novo_endereco}, 32'd6);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] pick;
            reg1 = 5'($urandom_range(0, 31));
            reg2 = 5'($urandom_range(0, 31));
            pick = 5'($urandom_range(0, 7));
            unique case (pick)
                5'd0:    reg_escrita = 5'd0;
                5'd1:    reg_escrita = 5'd24;
                5'd2:    reg_escrita = 5'd30;
                5'd3:    reg_escrita = 5'd16;
                default: reg_escrita = 5'($urandom_range(0, 31));
            endcase
            reg_write = 1'($urandom_range(0, 1));
            escreve_dado = $urandom;
            clear_offset_base = ($urandom_range(0, 9) == 0);
            beq = 1'($urandom_range(0, 1));
            bne = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            imediato = $urandom;
            pc_atual = 13'($urandom);
            #1;
            chk_all($sformatf("rnd%0d", i));
            edge_update();
        end
        reg_write = 1'b0;
        clear_offset_base = 1'b0;
        #1;
        chk_all("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
